// File: rtl/io_image_peripherals.sv
// io_image_peripherals: bit-addressed input image / output shadow with a snapshot/commit controller.
// Optional per-channel input debounce is compiled in when IO_DEBOUNCE_EN is defined.
module io_image_peripherals #(
  parameter int unsigned N_IN       = 16,
  parameter int unsigned N_OUT      = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DEB_CYCLES = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_IN-1:0]   INPUTS,
  output logic [N_OUT-1:0]  OUTPUTS,
  input  logic              SNAP_REQ,
  input  logic              COMMIT_REQ,
  input  logic              BIT_EN,
  input  logic              BIT_WE,
  input  logic [ADDR_W-1:0] BIT_ADDR,
  input  logic              BIT_WDATA,
  output logic              BIT_RDATA,
  output logic              BIT_VALID,
  output logic              BIT_ERR,
  output logic              BUSY
);

  if (N_IN < 1 || N_IN > 64 || N_OUT < 1 || N_OUT > 64 ||
      DEB_CYCLES < 2 || DEB_CYCLES > 255) begin : g_param_check
    $error("io_image_peripherals: parameter out of range");
  end

  // Address is widened so N_IN+N_OUT never wraps, even for narrow ADDR_W.
  localparam int unsigned      AX_W    = ADDR_W + 8;
  localparam logic [AX_W-1:0]  IN_LIM  = AX_W'(N_IN);
  localparam logic [AX_W-1:0]  OUT_LIM = AX_W'(N_IN + N_OUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SNAP,
    S_COMMIT
  } state_t;

  state_t            state_q, state_d;
  logic              pend_snap_q, pend_snap_d;
  logic              pend_commit_q, pend_commit_d;
  logic [N_IN-1:0]   sync1_q, sync2_q;
  logic [N_IN-1:0]   filt;
  logic [N_IN-1:0]   image_q;
  logic [N_OUT-1:0]  shadow_q, shadow_d;
  logic [N_OUT-1:0]  outputs_q;
  logic              rdata_q, rdata_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              busy, accept, in_hit, sh_hit, rd_bit;
  logic [AX_W-1:0]   addr_x;

  assign addr_x = AX_W'(BIT_ADDR);

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= INPUTS;
      sync2_q <= sync1_q;
    end
  end

`ifdef IO_DEBOUNCE_EN
  logic [N_IN-1:0] filt_q, filt_d;
  logic [7:0]      cnt_q [N_IN];
  logic [7:0]      cnt_d [N_IN];

  // A channel flips only after DEB_CYCLES consecutive disagreeing samples.
  always_comb begin
    filt_d = filt_q;
    for (int unsigned i = 0; i < N_IN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == 8'(DEB_CYCLES - 1)) begin
          filt_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      filt_q <= '0;
      for (int unsigned i = 0; i < N_IN; i++) cnt_q[i] <= '0;
    end else begin
      filt_q <= filt_d;
      for (int unsigned i = 0; i < N_IN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync2_q;
`endif

  always_comb begin
    state_d       = state_q;
    pend_snap_d   = pend_snap_q;
    pend_commit_d = pend_commit_q;
    case (state_q)
      S_IDLE: begin
        if (COMMIT_REQ || pend_commit_q) begin
          state_d       = S_COMMIT;
          pend_commit_d = 1'b0;
          pend_snap_d   = pend_snap_q || SNAP_REQ;
        end else if (SNAP_REQ || pend_snap_q) begin
          state_d     = S_SNAP;
          pend_snap_d = 1'b0;
        end
      end
      default: begin
        state_d       = S_IDLE;
        pend_snap_d   = pend_snap_q || SNAP_REQ;
        pend_commit_d = pend_commit_q || COMMIT_REQ;
      end
    endcase
  end

  always_comb begin
    busy   = (state_q != S_IDLE);
    accept = BIT_EN && !busy;
    in_hit = (addr_x < IN_LIM);
    sh_hit = (addr_x >= IN_LIM) && (addr_x < OUT_LIM);
    rd_bit = 1'b0;
    for (int unsigned i = 0; i < N_IN; i++)
      if (addr_x == AX_W'(i)) rd_bit = image_q[i];
    for (int unsigned j = 0; j < N_OUT; j++)
      if (addr_x == AX_W'(N_IN + j)) rd_bit = shadow_q[j];

    shadow_d = shadow_q;
    if (accept && BIT_WE && sh_hit) begin
      for (int unsigned j = 0; j < N_OUT; j++)
        if (addr_x == AX_W'(N_IN + j)) shadow_d[j] = BIT_WDATA;
    end

    rdata_d = 1'b0;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (accept) begin
      if (BIT_WE ? sh_hit : (in_hit || sh_hit)) begin
        valid_d = 1'b1;
        rdata_d = BIT_WE ? 1'b0 : rd_bit;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      pend_snap_q   <= 1'b0;
      pend_commit_q <= 1'b0;
      image_q       <= '0;
      shadow_q      <= '0;
      outputs_q     <= '0;
      rdata_q       <= 1'b0;
      valid_q       <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_snap_q   <= pend_snap_d;
      pend_commit_q <= pend_commit_d;
      shadow_q      <= shadow_d;
      rdata_q       <= rdata_d;
      valid_q       <= valid_d;
      err_q         <= err_d;
      if (state_q == S_SNAP)   image_q   <= filt;
      if (state_q == S_COMMIT) outputs_q <= shadow_q;
    end
  end

  assign OUTPUTS   = outputs_q;
  assign BIT_RDATA = rdata_q;
  assign BIT_VALID = valid_q;
  assign BIT_ERR   = err_q;
  assign BUSY      = busy;

endmodule

// File: doc/io_image_peripherals.md
IO_IMAGE_PERIPHERALS -- requirements
Module: io_image_peripherals

Interface
REQ-001 SHALL have parameter N_IN, default 16, number of digital input channels (1..64).
REQ-002 SHALL have parameter N_OUT, default 16, number of digital output channels (1..64).
REQ-003 SHALL have parameter ADDR_W, default 16, bit-address width.
REQ-004 SHALL have parameter DEB_CYCLES, default 8, debounce stability count (2..255).
REQ-005 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port RST  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port INPUTS  input  N_IN  raw asynchronous field inputs.
REQ-008 SHALL have port OUTPUTS  output  N_OUT  registered field outputs.
REQ-009 SHALL have port SNAP_REQ  input  1  request to capture the input image.
REQ-010 SHALL have port COMMIT_REQ  input  1  request to copy the output shadow to OUTPUTS.
REQ-011 SHALL have port BIT_EN  input  1  bit-access strobe.
REQ-012 SHALL have port BIT_WE  input  1  1 = write, 0 = read; qualified by BIT_EN.
REQ-013 SHALL have port BIT_ADDR  input  ADDR_W  bit address.
REQ-014 SHALL have port BIT_WDATA  input  1  write data.
REQ-015 SHALL have port BIT_RDATA  output  1  read data, valid with BIT_VALID.
REQ-016 SHALL have port BIT_VALID  output  1  one-cycle pulse: access completed.
REQ-017 SHALL have port BIT_ERR  output  1  one-cycle pulse: access rejected.
REQ-018 SHALL have port BUSY  output  1  high while in SNAP or COMMIT state.

Function
REQ-019 Address map SHALL be: 0..N_IN-1 = input image (read-only); N_IN..N_IN+N_OUT-1 = output shadow (read/write); all other addresses out of range.
REQ-020 Every input SHALL pass through a two-flop synchronizer before any further use.
REQ-021 Controller SHALL have states IDLE, SNAP, COMMIT; each of SNAP and COMMIT lasts exactly one cycle, then returns to IDLE.
REQ-022 In IDLE, COMMIT_REQ=1 SHALL enter COMMIT; else SNAP_REQ=1 SHALL enter SNAP; a SNAP_REQ coincident with COMMIT_REQ SHALL be held pending and serviced in the cycle after COMMIT.
REQ-023 SNAP SHALL copy all filtered inputs into the input image; COMMIT SHALL copy the output shadow into OUTPUTS.
REQ-024 Requests arriving while BUSY=1 SHALL be latched as pending and serviced on the next IDLE cycle, COMMIT before SNAP; duplicate requests SHALL merge.
REQ-025 Bit accesses SHALL be accepted only when BIT_EN=1 and BUSY=0; when BUSY=1 none of BIT_VALID, BIT_ERR, or state changes SHALL occur; the master holds the access.
REQ-026 Accepted read: BIT_RDATA and BIT_VALID SHALL appear exactly one cycle after acceptance.
REQ-027 Accepted write to the output-shadow range SHALL update the shadow bit at the acceptance edge and pulse BIT_VALID one cycle later; OUTPUTS SHALL be unchanged until the next COMMIT.
REQ-028 A write to the input range, or any access out of range, SHALL change no state and pulse BIT_ERR (not BIT_VALID) one cycle later; BIT_RDATA SHALL be 0.
REQ-029 A write accepted in the same cycle a COMMIT is requested SHALL be included in that COMMIT.
REQ-030 Address comparison SHALL use full ADDR_W width with no wrap-around or aliasing.

Reset
REQ-031 On RST=1 at a clock edge: OUTPUTS, output shadow, input image, synchronizers, filters, debounce counters, BIT_RDATA, BIT_VALID, BIT_ERR, BUSY SHALL be 0; state IDLE; pending requests cleared.
REQ-032 RST SHALL override everything, including mid-SNAP or mid-COMMIT; an interrupted COMMIT SHALL leave OUTPUTS = 0.

Configuration
REQ-033 With macro IO_DEBOUNCE_EN defined, each filtered input SHALL change only after its synchronized value has differed from the filtered value for DEB_CYCLES consecutive cycles; any reversion SHALL clear that channel's counter.
REQ-034 Without IO_DEBOUNCE_EN, the filtered input SHALL equal the synchronizer output and no counters SHALL exist.

Verification
REQ-035 Reset, then INPUTS=16'hA5A5, wait 4 cycles, pulse SNAP_REQ (no macro); read addresses 0..15 -> BIT_RDATA reproduces 16'hA5A5, each with BIT_VALID one cycle after acceptance.
REQ-036 Write 1 to addresses 16 and 31 -> OUTPUTS stays 16'h0000; pulse COMMIT_REQ -> OUTPUTS=16'h8001 two cycles later.
REQ-037 Write to address 3, then read address 40 -> BIT_ERR pulses for each, BIT_VALID=0, input image unchanged.
REQ-038 SNAP_REQ and COMMIT_REQ asserted together -> BUSY high 2 cycles; COMMIT precedes SNAP; a read held during BUSY completes on the first IDLE cycle.
REQ-039 With IO_DEBOUNCE_EN and DEB_CYCLES=8: toggle INPUTS[0] high for 5 cycles -> filtered value stays 0; hold high 12 cycles -> filtered value becomes 1 and SNAP captures it.
REQ-040 Assert RST in the COMMIT cycle after shadow=16'hFFFF -> OUTPUTS=0, BUSY=0, shadow=0 on the next cycle.
